// File: rtl/rt_pkg.sv
// Shared types and constants for the reaction-time game sequencer.
//  state_e    : game FSM states
//  LFSR_SEED  : reset value of the 16-bit delay LFSR
//  LFSR_TAPS  : Fibonacci tap mask (taps 16,14,13,11 -> bits 15,13,12,10)
//  BCD_MAX    : saturation value of the 4-digit BCD time counter
package rt_pkg;

    localparam int unsigned LFSR_W = 16;
    localparam int unsigned BCD_W  = 16;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
    localparam logic [BCD_W-1:0]  BCD_MAX   = 16'h9999;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        DONE,
        FOUL
    } state_e;

    // One Fibonacci step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/rt_bcd_counter.sv
// 4-digit BCD counter used for the reaction time.
//  clk, rst_n : clock, async active-low reset
//  clr_i      : synchronous clear to 0000 (has priority over inc_i)
//  inc_i      : increment by one, per-digit 9->0 with carry; held at 9999
//  bcd_o      : registered count, [15:12] = thousands
//  sat_o      : registered flag, high while the count is 9999
module rt_bcd_counter
    import rt_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [BCD_W-1:0] bcd_o,
    output logic             sat_o
);

    localparam int unsigned DIGITS = BCD_W / 4;

    logic [BCD_W-1:0] cnt_q, cnt_d;
    logic             sat_q;
    logic             carry;

    // Ripple the increment through the digits; saturated count never wraps.
    always_comb begin
        cnt_d = cnt_q;
        carry = 1'b1;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_q) begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (carry) begin
                    if (cnt_q[4*i +: 4] == 4'd9) begin
                        cnt_d[4*i +: 4] = 4'd0;
                    end else begin
                        cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                        carry           = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= (cnt_d == BCD_MAX);
        end
    end

    assign bcd_o = cnt_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game sequencer: random pre-LED delay after START, then a
// millisecond BCD count until REACT; flags false starts and timeouts.
//  clk, rst_n      : clock, async active-low reset
//  start_btn       : raw async start button (active high)
//  react_btn       : raw async react button (active high)
//  led             : stimulus LED, high only in RUN
//  time_bcd[15:0]  : running / final time, 4 BCD digits
//  result_valid    : 1-cycle pulse when a result (normal or timeout) is latched
//  foul            : high in FOUL (react before LED)
//  timeout         : high in DONE when the count saturated at 9999
//  busy            : high in ARM or RUN
//  best_bcd[15:0]  : best valid time
// Optional feature macro RT_BEST_TIME_EN: keeps a best-time register;
// without it best_bcd is the constant 9999.
module reaction_game_ctrl
    import rt_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 10_000_000,
    parameter int unsigned TICK_HZ      = 1_000,
    parameter int unsigned MIN_DELAY_MS = 1000,
    parameter int unsigned RAND_BITS    = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_btn,
    input  logic             react_btn,
    output logic             led,
    output logic [BCD_W-1:0] time_bcd,
    output logic             result_valid,
    output logic             foul,
    output logic             timeout,
    output logic             busy,
    output logic [BCD_W-1:0] best_bcd
);

    localparam int unsigned TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PRE_W    = $clog2(TICK_DIV);
    localparam int unsigned DLY_W    = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));

    state_e            state_q, state_d;
    logic [2:0]        start_sync_q, react_sync_q;
    logic              start_rise_c, react_rise_c;
    logic [PRE_W-1:0]  presc_q;
    logic              tick_c, presc_clr_c;
    logic [LFSR_W-1:0] lfsr_q;
    logic [DLY_W-1:0]  delay_q, delay_d;
    logic              led_q, result_valid_q, foul_q, timeout_q, busy_q;
    logic              result_valid_d, timeout_d;
    logic              cnt_clr_c, cnt_inc_c, cnt_sat;
    logic [BCD_W-1:0]  cnt_bcd;

    // Two flops of synchronisation plus one of history for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync_q <= '0;
            react_sync_q <= '0;
        end else begin
            start_sync_q <= {start_sync_q[1:0], start_btn};
            react_sync_q <= {react_sync_q[1:0], react_btn};
        end
    end

    assign start_rise_c = start_sync_q[1] & ~start_sync_q[2];
    assign react_rise_c = react_sync_q[1] & ~react_sync_q[2];

    // Tick prescaler; restarted on ARM/RUN entry so the first tick is a full period later.
    assign tick_c = (presc_q == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (presc_clr_c || tick_c) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + PRE_W'(1);
        end
    end

    // Free-running delay LFSR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    // FSM next state; react wins over a coincident tick in ARM and RUN.
    always_comb begin
        state_d        = state_q;
        delay_d        = delay_q;
        timeout_d      = timeout_q;
        result_valid_d = 1'b0;
        presc_clr_c    = 1'b0;
        cnt_clr_c      = 1'b0;
        cnt_inc_c      = 1'b0;
        case (state_q)
            IDLE, DONE, FOUL: begin
                if (start_rise_c) begin
                    state_d     = ARM;
                    delay_d     = DLY_W'(MIN_DELAY_MS) + DLY_W'(lfsr_q[RAND_BITS-1:0]);
                    timeout_d   = 1'b0;
                    presc_clr_c = 1'b1;
                end
            end
            ARM: begin
                if (react_rise_c) begin
                    state_d = FOUL;
                end else if (tick_c) begin
                    if (delay_q == DLY_W'(1)) begin
                        state_d     = RUN;
                        cnt_clr_c   = 1'b1;
                        presc_clr_c = 1'b1;
                    end else begin
                        delay_d = delay_q - DLY_W'(1);
                    end
                end
            end
            RUN: begin
                if (react_rise_c) begin
                    state_d        = DONE;
                    result_valid_d = 1'b1;
                end else if (tick_c) begin
                    if (cnt_sat) begin
                        state_d        = DONE;
                        timeout_d      = 1'b1;
                        result_valid_d = 1'b1;
                    end else begin
                        cnt_inc_c = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            delay_q        <= '0;
            led_q          <= 1'b0;
            result_valid_q <= 1'b0;
            foul_q         <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            delay_q        <= delay_d;
            led_q          <= (state_d == RUN);
            result_valid_q <= result_valid_d;
            foul_q         <= (state_d == FOUL);
            timeout_q      <= timeout_d;
            busy_q         <= (state_d == ARM) || (state_d == RUN);
        end
    end

    rt_bcd_counter u_bcd_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr_c),
        .inc_i (cnt_inc_c),
        .bcd_o (cnt_bcd),
        .sat_o (cnt_sat)
    );

`ifdef RT_BEST_TIME_EN
    logic [BCD_W-1:0] best_q, best_d;

    // Only a react result can improve the best; BCD orders like binary.
    always_comb begin
        best_d = best_q;
        if (result_valid_d && !timeout_d && (cnt_bcd < best_q)) begin
            best_d = cnt_bcd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q <= BCD_MAX;
        end else begin
            best_q <= best_d;
        end
    end

    assign best_bcd = best_q;
`else
    assign best_bcd = BCD_MAX;
`endif

    assign led          = led_q;
    assign time_bcd     = cnt_bcd;
    assign result_valid = result_valid_q;
    assign foul         = foul_q;
    assign timeout      = timeout_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Self-checking bench for reaction_game_ctrl (4 clk per tick, 2..5 tick delay).
module tb_reaction_game_ctrl;

    localparam int unsigned CLK_HZ  = 4000;
    localparam int unsigned TICK_HZ = 1000;
    localparam int unsigned MIN_DLY = 2;
    localparam int unsigned RBITS   = 2;
    localparam int unsigned TPC     = CLK_HZ / TICK_HZ;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start_btn = 1'b0;
    logic        react_btn = 1'b0;
    logic        led, result_valid, foul, timeout, busy;
    logic [15:0] time_bcd, best_bcd;

    int unsigned cyc      = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned m_best   = 9999;
    logic [15:0] m_lfsr;

    reaction_game_ctrl #(
        .CLK_HZ       (CLK_HZ),
        .TICK_HZ      (TICK_HZ),
        .MIN_DELAY_MS (MIN_DLY),
        .RAND_BITS    (RBITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_btn    (start_btn),
        .react_btn    (react_btn),
        .led          (led),
        .time_bcd     (time_bcd),
        .result_valid (result_valid),
        .foul         (foul),
        .timeout      (timeout),
        .busy         (busy),
        .best_bcd     (best_bcd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Reference LFSR sequence: seed at reset, one step per clock.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= lfsr_step(m_lfsr);
    end

    function automatic logic [15:0] to_bcd(input int unsigned v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] exp_best();
`ifdef RT_BEST_TIME_EN
        return to_bcd(m_best);
`else
        return 16'h9999;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        start_btn = 1'b0;
        react_btn = 1'b0;
        m_best    = 9999;
        repeat (3) step();
        rst_n = 1'b1;
        step();
    endtask

    // Press start now; returns the expected ARM-entry and LED-rise cycles.
    task automatic start_game(input bit want01, output int unsigned c_arm, output int unsigned c_led);
        logic [15:0] nxt;
        int          guard = 0;
        nxt = lfsr_step(lfsr_step(m_lfsr));
        while (want01 && nxt[1:0] != 2'b01 && guard < 64) begin
            step();
            nxt = lfsr_step(lfsr_step(m_lfsr));
            guard++;
        end
        start_btn = 1'b1;
        c_arm     = cyc + 3;
        c_led     = c_arm + TPC * (MIN_DLY + int'(nxt[RBITS-1:0]));
        step();
        start_btn = 1'b0;
    endtask

    // Walk through ARM checking busy/led, optionally poking start (must be ignored).
    task automatic wait_led(input int unsigned c_arm, input int unsigned c_led, input bit poke);
        int unsigned seen = 0;
        while (seen == 0 && cyc < c_led + 8) begin
            step();
            if (poke && cyc == c_arm + 2) start_btn = 1'b1;
            if (poke && cyc == c_arm + 3) start_btn = 1'b0;
            if (led === 1'b1) seen = cyc;
            if (cyc >= c_arm && cyc < c_led) begin
                n_checks++;
                if (busy !== 1'b1 || led !== 1'b0) begin
                    n_fail++;
                    $display("FAIL arm_state cyc=%0d busy=%b led=%b, required busy=1 led=0", cyc, busy, led);
                end
            end
        end
        n_checks++;
        if (seen != c_led) begin
            n_fail++;
            $display("FAIL led_rise cycle=%0d, required %0d", seen, c_led);
        end
    endtask

    // React react_off cycles after LED rise; model: ticks strictly before the react edge.
    task automatic play_run(input int unsigned c_led, input int unsigned react_off, input bit poke);
        int unsigned c_fsm   = c_led + react_off + 3;
        int unsigned exp_cnt = (react_off + 2) / TPC;
        int unsigned pulses  = 0;
        int unsigned c_pulse = 0;
        while (cyc < c_led + react_off) begin
            step();
            if (poke && cyc == c_led + 1) start_btn = 1'b1;
            if (poke && cyc == c_led + 2) start_btn = 1'b0;
        end
        n_checks++;
        if (time_bcd !== to_bcd(react_off / TPC) || led !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL run_count time=%h led=%b busy=%b, required time=%h led=1 busy=1",
                     time_bcd, led, busy, to_bcd(react_off / TPC));
        end
        react_btn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            react_btn = 1'b0;
            if (result_valid === 1'b1) begin
                pulses++;
                c_pulse = cyc;
            end
        end
        if (exp_cnt < m_best) m_best = exp_cnt;
        n_checks++;
        if (pulses != 1 || c_pulse != c_fsm) begin
            n_fail++;
            $display("FAIL result_pulse count=%0d at=%0d, required 1 at %0d", pulses, c_pulse, c_fsm);
        end
        n_checks++;
        if (time_bcd !== to_bcd(exp_cnt)) begin
            n_fail++;
            $display("FAIL result_time got=%h, required %h", time_bcd, to_bcd(exp_cnt));
        end
        n_checks++;
        if (led !== 1'b0 || foul !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_flags led=%b foul=%b timeout=%b busy=%b, required all 0", led, foul, timeout, busy);
        end
        n_checks++;
        if (best_bcd !== exp_best()) begin
            n_fail++;
            $display("FAIL best_after_result got=%h, required %h", best_bcd, exp_best());
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (led !== 1'b0 || result_valid !== 1'b0 || foul !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags led=%b rv=%b foul=%b to=%b busy=%b, required all 0",
                     led, result_valid, foul, timeout, busy);
        end
        n_checks++;
        if (time_bcd !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_time got=%h, required 0000", time_bcd);
        end
        n_checks++;
        if (best_bcd !== 16'h9999) begin
            n_fail++;
            $display("FAIL reset_best got=%h, required 9999", best_bcd);
        end
    endtask

    task automatic test_first_game();
        int unsigned ca, cl;
        start_game(1'b1, ca, cl);
        wait_led(ca, cl, 1'b0);
        play_run(cl, 37 * TPC, 1'b0);
    endtask

    task automatic test_foul();
        int unsigned ca, cl;
        int unsigned pulses   = 0;
        bit          led_seen = 1'b0;
        start_game(1'b0, ca, cl);
        while (cyc < ca + 1) step();
        react_btn = 1'b1;
        step();
        react_btn = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (result_valid === 1'b1) pulses++;
            if (led !== 1'b0) led_seen = 1'b1;
            if (cyc == ca + 4) begin
                n_checks++;
                if (foul !== 1'b1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL foul_entry foul=%b busy=%b, required foul=1 busy=0", foul, busy);
                end
            end
        end
        n_checks++;
        if (led_seen || pulses != 0 || foul !== 1'b1) begin
            n_fail++;
            $display("FAIL foul_hold led_seen=%0d pulses=%0d foul=%b, required 0 0 1", led_seen, pulses, foul);
        end
        start_game(1'b0, ca, cl);
        while (cyc < ca) step();
        n_checks++;
        if (foul !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL foul_restart foul=%b busy=%b, required foul=0 busy=1", foul, busy);
        end
        wait_led(ca, cl, 1'b0);
        play_run(cl, 60, 1'b0);
    endtask

    // React edge lands on a tick edge (37+3 = 10 periods); start pokes in ARM and RUN.
    task automatic test_coincident();
        int unsigned ca, cl;
        start_game(1'b0, ca, cl);
        wait_led(ca, cl, 1'b1);
        play_run(cl, 37, 1'b1);
    endtask

    task automatic test_random();
        int unsigned ca, cl;
        for (int r = 0; r < 5; r++) begin
            repeat ($urandom_range(0, 7)) step();
            start_game(1'b0, ca, cl);
            wait_led(ca, cl, 1'($urandom_range(0, 1)));
            play_run(cl, $urandom_range(5, 300), 1'($urandom_range(0, 1)));
        end
    endtask

    // Results 250, 180, 300 then a saturating timeout.
    task automatic test_best_time();
        int unsigned ca, cl;
        int unsigned offs [3] = '{250 * TPC, 180 * TPC, 300 * TPC};
        int unsigned pulses  = 0;
        int unsigned c_pulse = 0;
        for (int r = 0; r < 3; r++) begin
            start_game(1'b0, ca, cl);
            wait_led(ca, cl, 1'b0);
            play_run(cl, offs[r], 1'b0);
        end
        start_game(1'b0, ca, cl);
        wait_led(ca, cl, 1'b0);
        while (cyc < cl + 10000 * TPC + 8) begin
            step();
            if (result_valid === 1'b1) begin
                pulses++;
                c_pulse = cyc;
            end
            if (cyc == cl + 1234 * TPC + 2) begin
                n_checks++;
                if (time_bcd !== 16'h1234) begin
                    n_fail++;
                    $display("FAIL run_carry got=%h, required 1234", time_bcd);
                end
            end
            if (cyc == cl + 9999 * TPC + 1) begin
                n_checks++;
                if (time_bcd !== 16'h9999 || led !== 1'b1) begin
                    n_fail++;
                    $display("FAIL sat_reached time=%h led=%b, required 9999 1", time_bcd, led);
                end
            end
        end
        n_checks++;
        if (pulses != 1 || c_pulse != cl + 10000 * TPC) begin
            n_fail++;
            $display("FAIL timeout_pulse count=%0d at=%0d, required 1 at %0d", pulses, c_pulse, cl + 10000 * TPC);
        end
        n_checks++;
        if (time_bcd !== 16'h9999 || timeout !== 1'b1 || led !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_state time=%h to=%b led=%b busy=%b, required 9999 1 0 0",
                     time_bcd, timeout, led, busy);
        end
        n_checks++;
        if (best_bcd !== exp_best()) begin
            n_fail++;
            $display("FAIL best_after_timeout got=%h, required %h", best_bcd, exp_best());
        end
    endtask

    task automatic test_reset_mid_run();
        int unsigned ca, cl;
        int unsigned pulses = 0;
        start_game(1'b0, ca, cl);
        wait_led(ca, cl, 1'b0);
        repeat (10) step();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (led !== 1'b0 || busy !== 1'b0 || time_bcd !== 16'h0000 || result_valid !== 1'b0 || best_bcd !== 16'h9999) begin
            n_fail++;
            $display("FAIL async_reset led=%b busy=%b time=%h rv=%b best=%h, required 0 0 0000 0 9999",
                     led, busy, time_bcd, result_valid, best_bcd);
        end
        m_best = 9999;
        step();
        step();
        rst_n = 1'b1;
        step();
        react_btn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            react_btn = 1'b0;
            if (result_valid === 1'b1 || busy !== 1'b0) pulses++;
        end
        n_checks++;
        if (pulses != 0 || foul !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_react events=%0d foul=%b, required 0 0", pulses, foul);
        end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_first_game();
        test_foul();
        test_coincident();
        test_random();
        apply_reset();
        test_best_time();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog cyc=%0d, required completion", cyc);
        $fatal(1);
    end

endmodule
